spiker_output_collector: RTL and testbench
==========================================

// Module: spiker_output_collector
// PURPOSE
//   Gathers the output-spike words streamed by the spiker core over one inference
//   frame and assembles them into the wide DATA_WIDTH spike vector.
//   A frame is N_STEPS timesteps of N_REG words each; a neuron bit is set if it
//   spiked in any timestep (bitwise OR).
//   Sits directly upstream of spiker_writer: drives its data_out and sample_i
//   inputs so the result lands in the spikes_result registers.
// PARAMETERS
//   WIDTH      32    bits per spike word (one register width)
//   N_REG      24    words per timestep
//   N_STEPS    16    timesteps per frame (>=1)
//   DATA_WIDTH 768   assembled vector width; must equal N_REG*WIDTH
// PORTS
//   clk_i        in   1           clock
//   rst_ni       in   1           reset; asynchronous assertion, active-low
//   start_i      in   1           pulse: clear accumulator, begin new frame
//   word_valid_i in   1           core presents word_data_i
//   word_ready_o out  1           collector accepts word this cycle
//   word_data_i  in   WIDTH       spike word; bit b of word k = neuron k*WIDTH+b
//   data_out_o   out  DATA_WIDTH  assembled vector (to spiker_writer data_out)
//   sample_o     out  1           1-cycle pulse: data_out_o final (to sample_i)
//   busy_o       out  1           frame in progress (state != IDLE)
//   step_cnt_o   out  $clog2(N_STEPS+1)  completed timesteps in current frame
// BEHAVIOUR
//   Reset: state=IDLE; accumulator, data_out_o, word index, step_cnt_o = 0;
//     word_ready_o, sample_o, busy_o = 0.
//   States: IDLE, COLLECT, SAMPLE.
//   IDLE: word_ready_o=0; valid words ignored (not accepted, not stored).
//     start_i -> accumulator=0, word_idx=0, step_cnt=0, next COLLECT.
//   COLLECT: word_ready_o=1 (combinational from state). On valid&ready:
//     acc[word_idx*WIDTH +: WIDTH] |= word_data_i; word_idx++.
//     word_idx==N_REG-1 on accept -> word_idx=0, step_cnt++.
//     Accept that completes step N_STEPS-1 -> next SAMPLE.
//   SAMPLE: exactly one cycle; sample_o=1, word_ready_o=0, next IDLE.
//   data_out_o is the accumulator register itself; holds its value in IDLE until
//     the next start_i.
//   Latency: last word accepted on edge t -> data_out_o contains it and
//     sample_o=1 in cycle t+1.
//   start_i while COLLECT: abort frame, clear accumulator and counters, stay
//     COLLECT; a word presented in that same cycle is dropped (ready still 1, but
//     the clear takes priority).
//   start_i while SAMPLE: sample_o still pulses this cycle with the finished
//     vector; next cycle clears and enters COLLECT (no IDLE cycle).
//   Counters never wrap mid-frame; word_idx wraps N_REG-1 -> 0 only at a step end.
//   Reset mid-frame: immediate return to reset values; no sample_o is produced.
// TESTING
//   1 N_STEPS=1: start, 24 words 0x0000_0001<<k -> sample_o 1 cycle after word 23;
//     data_out_o[k*32+k]=1 for all k, all other bits 0.
//   2 N_STEPS=2: step0 word3=0x0F, step1 word3=0xF0 -> data_out_o[127:96]=0xFF;
//     step_cnt_o reads 1 between steps; sample_o after the 48th accept only.
//   3 Idle traffic: word_valid_i=1, data 0xFFFF_FFFF before start -> word_ready_o=0,
//     data_out_o unchanged, no sample_o.
//   4 Back-pressure gaps: random valid deassertion in a frame -> identical vector
//     to gap-free run; sample_o count = 1 per frame.
//   5 start_i at word 10 of step 0 -> accumulator 0 next cycle, full fresh frame
//     needed for sample_o; start_i in SAMPLE -> pulse seen, then busy_o stays 1.
//   6 rst_ni low mid-frame -> all outputs 0 asynchronously; after release, IDLE
//     until start_i.

Source files
------------

// File: rtl/spiker_output_collector.sv
// Collects per-timestep spike words from the spiker core and ORs them
// into one wide spike vector, pulsing sample_o when the frame is done.
module spiker_output_collector #(
  parameter int WIDTH      = 32,
  parameter int N_REG      = 24,
  parameter int N_STEPS    = 16,
  parameter int DATA_WIDTH = 768
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic                         word_valid_i,
  output logic                         word_ready_o,
  input  logic [WIDTH-1:0]             word_data_i,
  output logic [DATA_WIDTH-1:0]        data_out_o,
  output logic                         sample_o,
  output logic                         busy_o,
  output logic [$clog2(N_STEPS+1)-1:0] step_cnt_o
);

  localparam int IW = (N_REG > 1) ? $clog2(N_REG) : 1;
  localparam int SW = $clog2(N_STEPS + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_SAMPLE  = 2'd2;

  logic [1:0]            state_q;
  logic [IW-1:0]         word_idx_q;
  logic [SW-1:0]         step_cnt_q;
  logic [DATA_WIDTH-1:0] acc_q;

  logic in_idle;
  logic in_collect;
  logic in_sample;
  logic accept;
  logic last_word;
  logic last_step;

  assign in_idle    = (state_q == S_IDLE);
  assign in_collect = (state_q == S_COLLECT);
  assign in_sample  = (state_q == S_SAMPLE);

  // a start in the same cycle wins over the word handshake
  assign accept    = in_collect & word_valid_i & ~start_i;
  assign last_word = (word_idx_q == IW'(N_REG - 1));
  assign last_step = (step_cnt_q == SW'(N_STEPS - 1));

  assign word_ready_o = in_collect;
  assign sample_o     = in_sample;
  assign busy_o       = ~in_idle;
  assign data_out_o   = acc_q;
  assign step_cnt_o   = step_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      word_idx_q <= '0;
      step_cnt_q <= '0;
      acc_q      <= '0;
    end else begin
      unique case (1'b1)
        in_collect: begin
          if (start_i) begin
            word_idx_q <= '0;
            step_cnt_q <= '0;
            acc_q      <= '0;
          end else if (accept) begin
            acc_q[word_idx_q*WIDTH +: WIDTH] <=
              acc_q[word_idx_q*WIDTH +: WIDTH] | word_data_i;
            if (last_word) begin
              word_idx_q <= '0;
              step_cnt_q <= step_cnt_q + SW'(1);
              if (last_step) state_q <= S_SAMPLE;
            end else begin
              word_idx_q <= word_idx_q + IW'(1);
            end
          end
        end
        in_sample: begin
          if (start_i) begin
            state_q    <= S_COLLECT;
            word_idx_q <= '0;
            step_cnt_q <= '0;
            acc_q      <= '0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          if (start_i) begin
            state_q    <= S_COLLECT;
            word_idx_q <= '0;
            step_cnt_q <= '0;
            acc_q      <= '0;
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spiker_output_collector.sv
// Directed bench for spiker_output_collector: one instance with a
// single-step frame and one with a two-step frame.
module tb_spiker_output_collector;

  logic clk;
  logic rst_n;

  logic         start1, valid1, ready1, sample1, busy1;
  logic [31:0]  data1;
  logic [767:0] dout1;
  logic [0:0]   step1;

  logic         start2, valid2, ready2, sample2, busy2;
  logic [31:0]  data2;
  logic [767:0] dout2;
  logic [1:0]   step2;

  int n_pass;
  int n_total;
  int nsamp2;
  int base;

  logic [767:0] exp_v;
  logic [767:0] gap_v;
  logic [31:0]  w [48];

  spiker_output_collector #(
    .WIDTH(32), .N_REG(24), .N_STEPS(1), .DATA_WIDTH(768)
  ) u1 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start1),
    .word_valid_i(valid1),
    .word_ready_o(ready1),
    .word_data_i (data1),
    .data_out_o  (dout1),
    .sample_o    (sample1),
    .busy_o      (busy1),
    .step_cnt_o  (step1)
  );

  spiker_output_collector #(
    .WIDTH(32), .N_REG(24), .N_STEPS(2), .DATA_WIDTH(768)
  ) u2 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start2),
    .word_valid_i(valid2),
    .word_ready_o(ready2),
    .word_data_i (data2),
    .data_out_o  (dout2),
    .sample_o    (sample2),
    .busy_o      (busy2),
    .step_cnt_o  (step2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (sample2 === 1'b1) nsamp2++;

  task automatic chk(input string tag, input logic [767:0] obs,
                     input logic [767:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
  endtask

  // called just after a negedge; returns just after the next one
  task automatic push2(input logic [31:0] d);
    valid2 = 1'b1;
    data2  = d;
    @(negedge clk);
    valid2 = 1'b0;
    data2  = 32'hFFFF_FFFF;
  endtask

  task automatic start_u2();
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
  endtask

  task automatic frame2(input bit gaps, output logic [767:0] res);
    start_u2();
    for (int k = 0; k < 48; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      push2(w[k]);
    end
    chk("frame_sample", 768'(sample2), 768'(1));
    res = dout2;
    @(negedge clk);
  endtask

  initial begin
    n_pass = 0; n_total = 0; nsamp2 = 0;
    rst_n = 1'b0;
    start1 = 0; valid1 = 0; data1 = '0;
    start2 = 0; valid2 = 0; data2 = '0;

    @(negedge clk);
    chk("rst_dout1", dout1, '0);
    chk("rst_ctl1", 768'({ready1, sample1, busy1, step1}), 768'(0));
    chk("rst_dout2", dout2, '0);
    chk("rst_ctl2", 768'({ready2, sample2, busy2, step2}), 768'(0));
    rst_n = 1'b1;

    // idle traffic is ignored
    valid2 = 1'b1; data2 = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    chk("idle_ready", 768'(ready2), 768'(0));
    chk("idle_dout", dout2, '0);
    chk("idle_busy", 768'(busy2), 768'(0));
    chk("idle_nsamp", 768'(nsamp2), 768'(0));
    valid2 = 1'b0;

    // single-step frame: diagonal pattern
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("t1_busy", 768'(busy1), 768'(1));
    chk("t1_ready", 768'(ready1), 768'(1));
    for (int k = 0; k < 24; k++) begin
      valid1 = 1'b1;
      data1  = 32'd1 << k;
      @(negedge clk);
      if (k == 22) chk("t1_nosamp", 768'(sample1), 768'(0));
    end
    valid1 = 1'b0;
    exp_v = '0;
    for (int k = 0; k < 24; k++) exp_v[k*32+k] = 1'b1;
    chk("t1_sample", 768'(sample1), 768'(1));
    chk("t1_dout", dout1, exp_v);
    @(negedge clk);
    chk("t1_after", 768'({sample1, busy1}), 768'(0));
    chk("t1_hold", dout1, exp_v);

    // two-step frame
    base = nsamp2;
    start_u2();
    for (int k = 0; k < 24; k++) push2(k == 3 ? 32'h0F : 32'h0);
    chk("t2_step_mid", 768'(step2), 768'(1));
    chk("t2_nosamp", 768'(nsamp2 - base), 768'(0));
    for (int k = 0; k < 24; k++) push2(k == 3 ? 32'hF0 : 32'h0);
    chk("t2_sample", 768'(sample2), 768'(1));
    chk("t2_word3", 768'(dout2[127:96]), 768'(32'hFF));
    exp_v = '0;
    exp_v[127:96] = 32'hFF;
    chk("t2_dout", dout2, exp_v);
    chk("t2_step_end", 768'(step2), 768'(2));
    @(negedge clk);
    chk("t2_idle", 768'({sample2, busy2}), 768'(0));
    chk("t2_nsamp", 768'(nsamp2 - base), 768'(1));

    // gapped vs gap-free with the same words
    for (int k = 0; k < 48; k++) w[k] = $urandom;
    exp_v = '0;
    for (int k = 0; k < 48; k++) exp_v[(k % 24)*32 +: 32] |= w[k];
    base = nsamp2;
    frame2(1'b1, gap_v);
    chk("t4_gap", gap_v, exp_v);
    chk("t4_nsamp_gap", 768'(nsamp2 - base), 768'(1));
    frame2(1'b0, gap_v);
    chk("t4_nogap", gap_v, exp_v);
    chk("t4_nsamp", 768'(nsamp2 - base), 768'(2));

    // abort at word 10, then restart from SAMPLE
    start_u2();
    for (int k = 0; k < 10; k++) push2(32'hFFFF_FFFF);
    start2 = 1'b1; valid2 = 1'b1; data2 = 32'hFFFF_FFFF;
    @(negedge clk);
    start2 = 1'b0; valid2 = 1'b0;
    chk("t5_clr", dout2, '0);
    chk("t5_ctl", 768'({busy2, ready2, step2}), 768'({2'b11, 2'd0}));
    base = nsamp2;
    exp_v = '0;
    for (int k = 0; k < 48; k++) begin
      push2(32'(k + 1));
      exp_v[(k % 24)*32 +: 32] |= 32'(k + 1);
      if (k == 46) chk("t5_nosamp", 768'(nsamp2 - base), 768'(0));
    end
    chk("t5_sample", 768'(sample2), 768'(1));
    chk("t5_dout", dout2, exp_v);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("t5_restart", 768'({busy2, ready2, sample2}), 768'(3'b110));
    chk("t5_rclr", dout2, '0);
    chk("t5_nsamp", 768'(nsamp2 - base), 768'(1));

    // asynchronous reset mid-frame
    for (int k = 0; k < 5; k++) push2(32'hA5A5_0000 | 32'(k));
    base = nsamp2;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_dout", dout2, '0);
    chk("t6_ctl", 768'({ready2, sample2, busy2, step2}), 768'(0));
    @(negedge clk);
    rst_n = 1'b1;
    valid2 = 1'b1; data2 = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    valid2 = 1'b0;
    chk("t6_idle", 768'({ready2, busy2}), 768'(0));
    chk("t6_hold", dout2, '0);
    chk("t6_nsamp", 768'(nsamp2 - base), 768'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
